// File: rtl/pong_pkg.sv
// Shared types and helpers for the Pong match sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    SETTLE,
    OVER
  } state_e;

  // Wait cycles after an increment before the counters show the new score
  localparam int unsigned SETTLE_CYCLES = 2;
  localparam int unsigned SETTLE_W      = 2;

  // Two BCD digits to binary; a non-decimal digit yields 0 so it never wins
  function automatic logic [6:0] bcd2_to_bin(input logic [3:0] dig1, input logic [3:0] dig0);
    logic [6:0] bin;
    if ((dig1 > 4'd9) || (dig0 > 4'd9)) begin
      bin = 7'd0;
    end else begin
      bin = (7'(dig1) * 7'd10) + 7'(dig0);
    end
    return bin;
  endfunction

endpackage

// File: rtl/pong_serve_timer.sv
// serve_timer: loadable down-counter that steps once per frame tick while enabled.
module serve_timer
  import pong_pkg::*;
#(
  parameter int unsigned TW       = 8,
  parameter int unsigned LOAD_VAL = 120
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic          tick,
  output logic [TW-1:0] count,
  output logic          done
);

  logic [TW-1:0] count_q, count_d;
  logic          done_q, done_d;

  // Load wins over a same-cycle tick; the count parks at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = TW'(LOAD_VAL);
    end else if (en && tick && (count_q != '0)) begin
      count_d = count_q - TW'(1);
    end
    done_d = (count_d == '0);
  end

  // Timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      done_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign done  = done_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer driving the two BCD score counters.
// Optional macro PONG_SERVE_DIR_EN: serve_dir points at the player who lost the last point.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned SERVE_TICKS = 120,
  parameter int unsigned TW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic       miss_l,
  input  logic       miss_r,
  input  logic [3:0] l_dig0,
  input  logic [3:0] l_dig1,
  input  logic [3:0] r_dig0,
  input  logic [3:0] r_dig1,
  output logic       inc_l,
  output logic       inc_r,
  output logic       clr,
  output logic       ball_hold,
  output logic       game_over,
  output logic       winner,
  output logic       serve_dir
);

  localparam logic [6:0] WIN_BIN = 7'(WIN_SCORE);

  state_e                state_q, state_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic                  inc_l_q, inc_l_d;
  logic                  inc_r_q, inc_r_d;
  logic                  clr_q, clr_d;
  logic                  hold_q, hold_d;
  logic                  over_q, over_d;
  logic                  winner_q, winner_d;
  logic                  dir_q, dir_d;
  logic                  t_load_c;
  logic [TW-1:0]         t_count;
  logic                  t_done;
  logic [6:0]            l_score_c, r_score_c;

  assign l_score_c = bcd2_to_bin(l_dig1, l_dig0);
  assign r_score_c = bcd2_to_bin(r_dig1, r_dig0);

  serve_timer #(
    .TW       (TW),
    .LOAD_VAL (SERVE_TICKS)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (t_load_c),
    .en    (state_q == SERVE),
    .tick  (tick),
    .count (t_count),
    .done  (t_done)
  );

  // Next-state and registered-output decode
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    inc_l_d  = 1'b0;
    inc_r_d  = 1'b0;
    clr_d    = 1'b0;
    hold_d   = hold_q;
    over_d   = over_q;
    winner_d = winner_q;
    dir_d    = dir_q;
    t_load_c = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d = 1'b1;
        if (start) begin
          clr_d    = 1'b1;
          over_d   = 1'b0;
          dir_d    = 1'b0;
          t_load_c = 1'b1;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        hold_d = 1'b1;
        if (tick && ((t_count == TW'(1)) || t_done)) begin
          hold_d  = 1'b0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        hold_d = 1'b0;
        if (miss_l && miss_r) begin
          // Simultaneous misses replay the point
          hold_d   = 1'b1;
          t_load_c = 1'b1;
          state_d  = SERVE;
        end else if (miss_l) begin
          inc_r_d  = 1'b1;
          hold_d   = 1'b1;
          settle_d = '0;
          state_d  = SETTLE;
`ifdef PONG_SERVE_DIR_EN
          dir_d    = 1'b0;
`endif
        end else if (miss_r) begin
          inc_l_d  = 1'b1;
          hold_d   = 1'b1;
          settle_d = '0;
          state_d  = SETTLE;
`ifdef PONG_SERVE_DIR_EN
          dir_d    = 1'b1;
`endif
        end
      end
      SETTLE: begin
        hold_d = 1'b1;
        if (settle_q == SETTLE_W'(SETTLE_CYCLES)) begin
          if (l_score_c >= WIN_BIN) begin
            over_d   = 1'b1;
            winner_d = 1'b0;
            state_d  = OVER;
          end else if (r_score_c >= WIN_BIN) begin
            over_d   = 1'b1;
            winner_d = 1'b1;
            state_d  = OVER;
          end else begin
            t_load_c = 1'b1;
            state_d  = SERVE;
          end
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      OVER: begin
        hold_d = 1'b1;
        over_d = 1'b1;
        if (start) begin
          clr_d    = 1'b1;
          over_d   = 1'b0;
          dir_d    = 1'b0;
          t_load_c = 1'b1;
          state_d  = SERVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves a clear pulse for the counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      settle_q <= '0;
      inc_l_q  <= 1'b0;
      inc_r_q  <= 1'b0;
      clr_q    <= 1'b1;
      hold_q   <= 1'b1;
      over_q   <= 1'b0;
      winner_q <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      inc_l_q  <= inc_l_d;
      inc_r_q  <= inc_r_d;
      clr_q    <= clr_d;
      hold_q   <= hold_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      dir_q    <= dir_d;
    end
  end

  assign inc_l     = inc_l_q;
  assign inc_r     = inc_r_q;
  assign clr       = clr_q;
  assign ball_hold = hold_q;
  assign game_over = over_q;
  assign winner    = winner_q;
  assign serve_dir = dir_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Testbench for pong_match_ctrl with stand-in BCD score counters.
module tb_pong_match_ctrl;

  localparam int unsigned WIN = 11;
  localparam int unsigned ST  = 120;

  logic       clk = 1'b0;
  logic       reset, start, tick, miss_l, miss_r;
  logic [3:0] l_dig0, l_dig1, r_dig0, r_dig1;
  logic       inc_l, inc_r, clr, ball_hold, game_over, winner, serve_dir;

  int checks = 0;
  int errors = 0;

  // Stand-in counters: increment becomes visible two cycles after inc
  int   l_cnt = 0, r_cnt = 0;
  logic l_pend = 1'b0, r_pend = 1'b0;

  // Reference model of the match
  int exp_l = 0, exp_r = 0;
  bit exp_over = 1'b0, exp_win = 1'b0, exp_dir = 1'b0;

  always #5 clk = ~clk;

  pong_match_ctrl #(.WIN_SCORE(WIN), .SERVE_TICKS(ST), .TW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .tick      (tick),
    .miss_l    (miss_l),
    .miss_r    (miss_r),
    .l_dig0    (l_dig0),
    .l_dig1    (l_dig1),
    .r_dig0    (r_dig0),
    .r_dig1    (r_dig1),
    .inc_l     (inc_l),
    .inc_r     (inc_r),
    .clr       (clr),
    .ball_hold (ball_hold),
    .game_over (game_over),
    .winner    (winner),
    .serve_dir (serve_dir)
  );

  always @(posedge clk) begin
    if (clr === 1'b1) begin
      l_cnt  <= 0;
      r_cnt  <= 0;
      l_pend <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      l_pend <= (inc_l === 1'b1);
      r_pend <= (inc_r === 1'b1);
      if (l_pend) l_cnt <= (l_cnt + 1) % 100;
      if (r_pend) r_cnt <= (r_cnt + 1) % 100;
    end
  end

  assign l_dig0 = 4'(l_cnt % 10);
  assign l_dig1 = 4'(l_cnt / 10);
  assign r_dig0 = 4'(r_cnt % 10);
  assign r_dig1 = 4'(r_cnt / 10);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic dir_model();
`ifdef PONG_SERVE_DIR_EN
    return exp_dir;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_l = 0; exp_r = 0; exp_over = 1'b0; exp_dir = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; start = 1'b0; tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    step();
    reset = 1'b0;
    chk({tag, "_clr"}, clr, 1);
    chk({tag, "_over"}, game_over, 0);
    chk({tag, "_hold"}, ball_hold, 1);
    chk({tag, "_winner"}, winner, 0);
    chk({tag, "_incs"}, {inc_l, inc_r}, 0);
    chk({tag, "_dir"}, serve_dir, 0);
    step();
    chk({tag, "_clr_done"}, clr, 0);
    chk({tag, "_idle_hold"}, ball_hold, 1);
    chk({tag, "_scores"}, l_cnt + r_cnt, 0);
    clear_model();
  endtask

  // Hold the serve with random ticks and ignored start/miss noise; count ticks until release
  task automatic serve_phase(input string tag);
    int n = 0, cyc = 0, stray = 0;
    while (ball_hold === 1'b1 && cyc < 3000) begin
      tick   = 1'($urandom_range(0, 1));
      start  = ($urandom_range(0, 9) == 0);
      miss_l = ($urandom_range(0, 9) == 0);
      miss_r = ($urandom_range(0, 9) == 0);
      if (tick) n++;
      step();
      cyc++;
      if (clr !== 1'b0 || inc_l !== 1'b0 || inc_r !== 1'b0) stray++;
    end
    tick = 1'b0; start = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    chk({tag, "_ticks"}, n, ST);
    chk({tag, "_stray"}, stray, 0);
  endtask

  // kind 0: left misses, 1: right misses, 2: both miss
  task automatic play_point(input int kind);
    int il = 0, ir = 0, ic = 0;
    chk("play_hold", ball_hold, 0);
    repeat ($urandom_range(0, 4)) begin
      tick  = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 2) == 0);
      step();
      il += int'(inc_l === 1'b1);
      ir += int'(inc_r === 1'b1);
      ic += int'(clr === 1'b1);
    end
    tick = 1'b0; start = 1'b0;
    miss_l = (kind != 1);
    miss_r = (kind != 0);
    step();
    miss_l = 1'b0; miss_r = 1'b0;
    for (int i = 0; i < 6; i++) begin
      il += int'(inc_l === 1'b1);
      ir += int'(inc_r === 1'b1);
      ic += int'(clr === 1'b1);
      step();
    end
    if (kind == 0) begin exp_r++; exp_dir = 1'b0; end
    else if (kind == 1) begin exp_l++; exp_dir = 1'b1; end
    if (exp_l >= int'(WIN)) begin exp_over = 1'b1; exp_win = 1'b0; end
    else if (exp_r >= int'(WIN)) begin exp_over = 1'b1; exp_win = 1'b1; end
    chk("inc_l_pulses", il, (kind == 1) ? 1 : 0);
    chk("inc_r_pulses", ir, (kind == 0) ? 1 : 0);
    chk("point_clr", ic, 0);
    chk("l_score", l_cnt, exp_l);
    chk("r_score", r_cnt, exp_r);
    chk("point_over", game_over, exp_over);
    chk("point_hold", ball_hold, 1);
    chk("point_dir", serve_dir, dir_model());
    if (exp_over) chk("point_winner", winner, exp_win);
  endtask

  task automatic restart(input string tag, input logic with_tick);
    start = 1'b1; tick = with_tick;
    step();
    start = 1'b0; tick = 1'b0;
    chk({tag, "_clr"}, clr, 1);
    chk({tag, "_over"}, game_over, 0);
    chk({tag, "_hold"}, ball_hold, 1);
    chk({tag, "_dir"}, serve_dir, 0);
    clear_model();
    serve_phase(tag);
    chk({tag, "_l_clear"}, l_cnt, 0);
    chk({tag, "_r_clear"}, r_cnt, 0);
  endtask

  task automatic run_match(input bit directed);
    int guard = 0;
    int kind;
    int r;
    while (!exp_over && guard < 200) begin
      if (directed) begin
        if (guard == 3) kind = 2;
        else if (exp_l < 10 && exp_l <= exp_r) kind = 1;
        else kind = 0;
      end else begin
        r = int'($urandom_range(0, 9));
        kind = (r < 5) ? 0 : ((r < 9) ? 1 : 2);
      end
      play_point(kind);
      if (!exp_over) serve_phase("serve");
      guard++;
    end
    chk("match_over", game_over, 1);
  endtask

  task automatic over_misses();
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      miss_l = (i < 4) && (i % 2 == 0);
      miss_r = (i < 4) && (i != 0);
      tick   = 1'($urandom_range(0, 1));
      step();
      n += int'(inc_l === 1'b1) + int'(inc_r === 1'b1) + int'(clr === 1'b1);
    end
    miss_l = 1'b0; miss_r = 1'b0; tick = 1'b0;
    chk("over_no_inc", n, 0);
    chk("over_held", game_over, 1);
    chk("over_hold", ball_hold, 1);
    chk("over_winner", winner, exp_win);
    chk("over_l_score", l_cnt, exp_l);
    chk("over_r_score", r_cnt, exp_r);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    do_reset("por");
    restart("m0", 1'b0);
    play_point(0);
    serve_phase("s1");
    play_point(2);
    serve_phase("s2");
    play_point(1);
    serve_phase("s3");
    do_reset("rst_play");
    restart("m1", 1'b0);
    run_match(1'b0);
    over_misses();
    restart("m2", 1'b1);
    run_match(1'b1);
    chk("directed_winner", winner, 1);
    do_reset("rst_over");
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (60) begin
      tick = 1'($urandom_range(0, 1));
      step();
    end
    tick = 1'b0;
    chk("mid_serve_hold", ball_hold, 1);
    do_reset("rst_serve");
    restart("m4", 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
